// File: rtl/serial_rx_deser.sv
// Single-wire frame receiver: start bit, DATA_WIDTH data bits LSB first, stop bit.
// Build option SERDES_RX_PARITY_EN inserts an even-parity bit and adds the parity_error port.
module serial_rx_deser #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BIT_CYCLES = 16
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  serial_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  frame_error,
`ifdef SERDES_RX_PARITY_EN
    output logic                  parity_error,
`endif
    output logic                  busy
);

    localparam int unsigned CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int unsigned BW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CYCLES / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef SERDES_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_IDLE
    } state_e;

    state_e                state_q, state_d;
    logic [1:0]            sync_q, sync_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  data_valid_q, data_valid_d;
    logic                  frame_error_q, frame_error_d;
`ifdef SERDES_RX_PARITY_EN
    logic                  par_q, par_d;
    logic                  parity_error_q, parity_error_d;
`endif
    logic                  rx_s;

    assign rx_s = sync_q[1];

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            sync_q         <= 2'b11;
            cnt_q          <= '0;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            data_out_q     <= '0;
            data_valid_q   <= 1'b0;
            frame_error_q  <= 1'b0;
`ifdef SERDES_RX_PARITY_EN
            par_q          <= 1'b0;
            parity_error_q <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            sync_q         <= sync_d;
            cnt_q          <= cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            data_out_q     <= data_out_d;
            data_valid_q   <= data_valid_d;
            frame_error_q  <= frame_error_d;
`ifdef SERDES_RX_PARITY_EN
            par_q          <= par_d;
            parity_error_q <= parity_error_d;
`endif
        end
    end

    // Every bit is sampled at its midpoint: half a bit after the start edge, then once per bit.
    always_comb begin
        state_d       = state_q;
        sync_d        = {sync_q[0], serial_in};
        cnt_d         = cnt_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        data_out_d    = data_out_q;
        data_valid_d  = 1'b0;
        frame_error_d = 1'b0;
`ifdef SERDES_RX_PARITY_EN
        par_d          = par_q;
        parity_error_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = rx_s ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s, shift_q[DATA_WIDTH-1:1]};
                    bit_cnt_d = bit_cnt_q + BW'(1);
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef SERDES_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`ifdef SERDES_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    par_d   = rx_s;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = S_IDLE;
`ifdef SERDES_RX_PARITY_EN
                        if ((^shift_q) ^ par_q) begin
                            parity_error_d = 1'b1;
                        end else begin
                            data_out_d   = shift_q;
                            data_valid_d = 1'b1;
                        end
`else
                        data_out_d   = shift_q;
                        data_valid_d = 1'b1;
`endif
                    end else begin
                        frame_error_d = 1'b1;
                        state_d       = S_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT_IDLE: begin
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign frame_error = frame_error_q;
`ifdef SERDES_RX_PARITY_EN
    assign parity_error = parity_error_q;
`endif
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_serial_rx_deser.sv
// Scoreboard bench for serial_rx_deser at BIT_CYCLES=4; stimulus pushes expected events,
// a negedge monitor pops and checks each data_valid / frame_error / parity_error pulse.
module tb_serial_rx_deser;

    localparam int unsigned DW = 8;
    localparam int unsigned BC = 4;

    localparam int K_VALID  = 0;
    localparam int K_FRAME  = 1;
    localparam int K_PARITY = 2;

    typedef struct {
        int          kind;
        logic [7:0]  data;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          serial_in = 1'b1;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          frame_error;
    logic          busy;
    logic          parity_err_w;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int last_valid_cyc = 0;
    int prev_valid_cyc = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    serial_rx_deser #(.DATA_WIDTH(DW), .BIT_CYCLES(BC)) dut (
        .CLOCK_50    (clk),
        .reset       (reset),
        .serial_in   (serial_in),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .frame_error (frame_error),
`ifdef SERDES_RX_PARITY_EN
        .parity_error(parity_err_w),
`endif
        .busy        (busy)
    );

`ifndef SERDES_RX_PARITY_EN
    assign parity_err_w = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    endtask

    // Monitor: every output pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        cyc++;
        if (!reset && (data_valid || frame_error || parity_err_w)) begin
            int kind;
            kind = data_valid ? K_VALID : (frame_error ? K_FRAME : K_PARITY);
            if (data_valid) begin
                prev_valid_cyc = last_valid_cyc;
                last_valid_cyc = cyc;
            end
            if ((int'(data_valid) + int'(frame_error) + int'(parity_err_w)) > 1)
                check("pulse_exclusive", 32'(int'(data_valid) + int'(frame_error) + int'(parity_err_w)), 32'd1);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse_kind", 32'(kind), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pulse_kind", 32'(kind), 32'(e.kind));
                check("pulse_data_out", 32'(data_out), 32'(e.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        serial_in = b;
        repeat (BC) tick();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop_b);
        logic [7:0] v;
        v = d;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(v[i]);
`ifdef SERDES_RX_PARITY_EN
        drive_bit(par);
`else
        if (par) begin end
`endif
        drive_bit(stop_b);
    endtask

    task automatic expect_evt(input int kind, input logic [7:0] d);
        exp_t e;
        e.kind = kind;
        e.data = d;
        exp_q.push_back(e);
    endtask

    initial begin
        // Reset then idle
        repeat (3) tick();
        check("reset_data_out", 32'(data_out), 32'h00);
        check("reset_data_valid", 32'(data_valid), 32'h0);
        check("reset_frame_error", 32'(frame_error), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        repeat (200) tick();
        check("idle_data_out", 32'(data_out), 32'h00);
        check("idle_busy", 32'(busy), 32'h0);

        // Single frame 0xA9 (even parity bit 0)
        expect_evt(K_VALID, 8'hA9);
        send_frame(8'hA9, 1'b0, 1'b1);
        repeat (6) tick();
        check("single_busy_after", 32'(busy), 32'h0);

        // Back-to-back 0x55 then 0x0F
        expect_evt(K_VALID, 8'h55);
        expect_evt(K_VALID, 8'h0F);
        send_frame(8'h55, 1'b0, 1'b1);
        send_frame(8'h0F, 1'b0, 1'b1);
        repeat (8) tick();
        check("b2b_spacing", 32'(last_valid_cyc - prev_valid_cyc), 32'(10 * BC));

        // One-cycle glitch: busy back low within BC/2+3 cycles
        serial_in = 1'b0;
        tick();
        serial_in = 1'b1;
        repeat (BC / 2 + 2) tick();
        check("glitch_busy", 32'(busy), 32'h0);
        repeat (10) tick();

        // Framing error: 0x3C with stop 0, line held low afterwards
        expect_evt(K_FRAME, 8'h0F);
        send_frame(8'h3C, 1'b0, 1'b0);
        serial_in = 1'b0;
        repeat (3 * BC) tick();
        check("wait_idle_busy", 32'(busy), 32'h1);
        check("ferr_data_out_held", 32'(data_out), 32'h0F);
        serial_in = 1'b1;
        repeat (6) tick();
        check("wait_idle_exit_busy", 32'(busy), 32'h0);

        // Mid-frame reset during data bit 4 of 0xA9
        drive_bit(1'b0);
        drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b0); drive_bit(1'b1);
        serial_in = 1'b0;
        repeat (BC / 2) tick();
        reset = 1'b1;
        #1;
        check("midreset_data_out", 32'(data_out), 32'h00);
        check("midreset_busy", 32'(busy), 32'h0);
        serial_in = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (5) tick();
        expect_evt(K_VALID, 8'h12);
        send_frame(8'h12, 1'b0, 1'b1);
        repeat (6) tick();
        check("post_reset_data_out", 32'(data_out), 32'h12);

`ifdef SERDES_RX_PARITY_EN
        expect_evt(K_VALID, 8'hA9);
        send_frame(8'hA9, 1'b0, 1'b1);
        repeat (4) tick();
        expect_evt(K_PARITY, 8'hA9);
        send_frame(8'hA9, 1'b1, 1'b1);
        repeat (6) tick();
        check("parity_data_out_held", 32'(data_out), 32'hA9);
`endif

        repeat (20) tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
